uart_tx_8n1: RTL and testbench

Byte-level UART transmitter producing 8N1 frames: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit. It sits at the data-link layer between the packet sender, which sequences multi-byte packets one byte at a time, and the board's FTDI serial line. The block latches a byte on a single-cycle `enable` request and reports `busy` for the whole frame.

---
 rtl/uart_tx_8n1_if.sv | 11 +
 rtl/uart_tx_8n1.sv | 148 ++++++++++++++
 tb/tb_uart_tx_8n1.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_8n1_if.sv
// Byte-request / serial-line bundle between the packet sender and uart_tx_8n1.
// master = packet sender side, slave = transmitter side.
interface uart_tx_8n1_if;
   logic [7:0] data;
   logic       enable;
   logic       busy;
   logic       txd;

   modport master (output data, output enable, input busy, input txd);
   modport slave  (input data, input enable, output busy, output txd);
endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: latches a byte on enable, shifts it out LSB first with busy high per frame.
// Optional build macro UART_TX_TWO_STOP_EN stretches the stop bit to two bit periods (8N2).
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | line high, waiting for enable
// S_START | start bit (txd=0)
// S_DATA  | data bit r_bit_idx of r_shift, LSB first
// S_STOP  | stop bit(s), txd=1
module uart_tx_8n1 #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_tx_8n1_if.slave  bus
);

   localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  LP_CNT_TC = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t        r_state,   w_state_nxt;
   logic [CW-1:0] r_cnt,     w_cnt_nxt;
   logic [2:0]    r_bit_idx, w_bit_idx_nxt;
   logic [7:0]    r_shift,   w_shift_nxt;
   logic          r_busy,    w_busy_nxt;
   logic          r_txd,     w_txd_nxt;
   logic          w_tc;
   logic [2:0]    w_idx_inc;
`ifdef UART_TX_TWO_STOP_EN
   logic          r_stop2,   w_stop2_nxt;
`endif

   assign w_tc      = (r_cnt == LP_CNT_TC);
   assign w_idx_inc = r_bit_idx + 3'd1;

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_busy_nxt    = r_busy;
      w_txd_nxt     = r_txd;
`ifdef UART_TX_TWO_STOP_EN
      w_stop2_nxt   = r_stop2;
`endif
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt  = '0;
            w_busy_nxt = 1'b0;
            w_txd_nxt  = 1'b1;
            if (bus.enable) begin
               w_state_nxt   = S_START;
               w_shift_nxt   = bus.data;
               w_bit_idx_nxt = 3'd0;
               w_busy_nxt    = 1'b1;
               w_txd_nxt     = 1'b0;
            end
         end
         S_START: begin
            if (w_tc) begin
               w_cnt_nxt     = '0;
               w_state_nxt   = S_DATA;
               w_bit_idx_nxt = 3'd0;
               w_txd_nxt     = r_shift[0];
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_DATA: begin
            if (w_tc) begin
               w_cnt_nxt = '0;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_txd_nxt   = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
                  w_stop2_nxt = 1'b0;
`endif
               end else begin
                  w_bit_idx_nxt = w_idx_inc;
                  w_txd_nxt     = r_shift[w_idx_inc];
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_STOP: begin
            if (w_tc) begin
               w_cnt_nxt = '0;
`ifdef UART_TX_TWO_STOP_EN
               // first terminal count only ends the first of the two stop periods
               if (!r_stop2) begin
                  w_stop2_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_busy_nxt  = 1'b0;
               end
`else
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
`endif
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_txd_nxt   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'd0;
         r_busy    <= 1'b0;
         r_txd     <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
         r_stop2   <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_busy    <= w_busy_nxt;
         r_txd     <= w_txd_nxt;
`ifdef UART_TX_TWO_STOP_EN
         r_stop2   <= w_stop2_nxt;
`endif
      end
   end

   assign bus.busy = r_busy;
   assign bus.txd  = r_txd;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Directed bench for uart_tx_8n1 at CLKS_PER_BIT=4: frame table plus reset, back-to-back and mid-frame reset sequences.
module tb_uart_tx_8n1;

   localparam int CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
   localparam int FL  = 11 * CPB;
`else
   localparam int FL  = 10 * CPB;
`endif

   logic clk;
   logic rst_n;
   uart_tx_8n1_if bus ();

   uart_tx_8n1 #(.CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] data;
      logic [0:9] line;      // start, d0..d7, stop in send order
      int         poke_c;    // frame cycle at which data/enable are disturbed, -1 none
      logic [7:0] poke_d;
      logic       poke_e;
      string      name;
   } vec_t;

   vec_t vecs [5];

   function automatic logic line_bit(input logic [0:9] line, input int c);
      return (c < 10 * CPB) ? line[c / CPB] : 1'b1;
   endfunction

   task automatic chk(input string nm, input int c, input logic b, input logic eb,
                      input logic t, input logic et);
      n_vec++;
      if (b !== eb) begin
         n_fail++;
         $display("FAIL %s busy cycle %0d: got %b expected %b", nm, c, b, eb);
      end
      n_vec++;
      if (t !== et) begin
         n_fail++;
         $display("FAIL %s txd cycle %0d: got %b expected %b", nm, c, t, et);
      end
   endtask

   // Called right after enable has been driven high at a negedge; checks the whole frame and the idle cycle after it.
   task automatic check_frame(input logic [0:9] line, input int poke_c, input logic [7:0] poke_d,
                              input logic poke_e, input int idle_after, input string nm);
      for (int c = 0; c < FL; c++) begin
         @(negedge clk);
         chk(nm, c, bus.busy, 1'b1, bus.txd, line_bit(line, c));
         if (c == 0) bus.enable = 1'b0;
         if (c == poke_c) begin
            bus.data   = poke_d;
            bus.enable = poke_e;
         end else if (c == poke_c + 1) begin
            bus.enable = 1'b0;
         end
      end
      for (int c = 0; c < idle_after; c++) begin
         @(negedge clk);
         chk(nm, FL + c, bus.busy, 1'b0, bus.txd, 1'b1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [0:9] l31, l32, l5a;
      logic [7:0] dec;

      vecs[0] = '{8'hA5, 10'b0101001011, -1, 8'h00, 1'b0, "byte_a5"};
      vecs[1] = '{8'h00, 10'b0000000001, 10, 8'h3C, 1'b1, "ignore_busy"};
      vecs[2] = '{8'h55, 10'b0101010101, 0,  8'hAA, 1'b0, "data_stable"};
      vecs[3] = '{8'hFF, 10'b0111111111, -1, 8'h00, 1'b0, "byte_ff"};
      vecs[4] = '{8'h3C, 10'b0001111001, -1, 8'h00, 1'b0, "byte_3c"};
      l31 = 10'b0100011001;
      l32 = 10'b0010011001;
      l5a = 10'b0010110101;

      // Reset held with a pending request
      rst_n      = 1'b0;
      bus.enable = 1'b1;
      bus.data   = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("reset", c, bus.busy, 1'b0, bus.txd, 1'b1);
      end
      rst_n      = 1'b1;
      bus.enable = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_reset", c, bus.busy, 1'b0, bus.txd, 1'b1);
      end

      // Frame table
      for (int v = 0; v < 5; v++) begin
         bus.data   = vecs[v].data;
         bus.enable = 1'b1;
         check_frame(vecs[v].line, vecs[v].poke_c, vecs[v].poke_d, vecs[v].poke_e, 6, vecs[v].name);
      end

      // Enable held high: two frames with exactly one idle cycle between them
      @(negedge clk);
      bus.data   = 8'h31;
      bus.enable = 1'b1;
      dec = 8'h00;
      for (int c = 0; c < 2 * FL + 5; c++) begin
         @(negedge clk);
         if (c < FL) begin
            chk("b2b_f1", c, bus.busy, 1'b1, bus.txd, line_bit(l31, c));
            if (c >= CPB && c < 9 * CPB && (c % CPB) == CPB / 2) dec[(c / CPB) - 1] = bus.txd;
         end else if (c == FL) begin
            chk("b2b_gap", c, bus.busy, 1'b0, bus.txd, 1'b1);
         end else if (c <= 2 * FL) begin
            chk("b2b_f2", c, bus.busy, 1'b1, bus.txd, line_bit(l32, c - FL - 1));
         end else begin
            chk("b2b_idle", c, bus.busy, 1'b0, bus.txd, 1'b1);
         end
         if (c == 20) bus.data = 8'h32;
         if (c == FL + 10) bus.enable = 1'b0;
      end
      n_vec++;
      if (dec !== 8'h31) begin
         n_fail++;
         $display("FAIL b2b_decode: got %h expected %h", dec, 8'h31);
      end

      // Reset during data bit 3, then a clean frame
      @(negedge clk);
      bus.data   = 8'hA5;
      bus.enable = 1'b1;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         chk("pre_abort", c, bus.busy, 1'b1, bus.txd, line_bit(10'b0101001011, c));
         if (c == 0) bus.enable = 1'b0;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort", 0, bus.busy, 1'b0, bus.txd, 1'b1);
      rst_n      = 1'b1;
      bus.data   = 8'h5A;
      bus.enable = 1'b1;
      check_frame(l5a, -1, 8'h00, 1'b0, 4, "after_abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
